// File: rtl/mdioconf_hst_arb.sv
// mdioconf_hst_arb: round-robin two-requester arbiter sequencing config and MIIM transactions onto the MAC host bus
module mdioconf_hst_arb #(
  parameter int CFG_RD_LAT = 2,
  parameter int TIMEOUT    = 4095
) (
  input  logic        host_clk,
  input  logic        host_reset,
  input  logic [1:0]  req_valid,
  input  logic [3:0]  req_opcode,
  input  logic [19:0] req_addr,
  input  logic [63:0] req_wr_data,
  input  logic [1:0]  req_miim_sel,
  output logic [1:0]  req_ack,
  output logic [1:0]  req_done,
  output logic [63:0] req_rd_data,
  output logic [1:0]  req_err,
  output logic [1:0]  host_opcode,
  output logic [9:0]  host_addr,
  output logic [31:0] host_wr_data,
  output logic        host_miim_sel,
  output logic        host_req,
  input  logic [31:0] host_rd_data,
  input  logic        host_miim_rdy
);
  typedef enum logic [2:0] {IDLE, CFG, MIIM_ARM, MIIM_GAP, MIIM_WAIT} state_t;
  state_t      state_q, state_d;
  logic        last_q, last_d, cur_q, cur_d, win;
  logic [11:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]  op_q, op_d, ack_q, ack_d, done_q, done_d, err_q, err_d;
  logic [9:0]  addr_q, addr_d;
  logic [31:0] wr_q, wr_d, fin_data;
  logic        sel_q, sel_d, hreq_q, hreq_d, fin, fin_err;
  logic [63:0] rd_q, rd_d;
  assign win     = &req_valid ? ~last_q : req_valid[1];
  assign cnt_inc = cnt_q + 12'd1;
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cur_d    = cur_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    sel_d    = sel_q;
    hreq_d   = 1'b0;
    ack_d    = 2'b00;
    done_d   = 2'b00;
    err_d    = 2'b00;
    rd_d     = rd_q;
    fin      = 1'b0;
    fin_err  = 1'b0;
    fin_data = 32'd0;
    case (state_q)
      IDLE: if (|req_valid) begin
        state_d    = req_miim_sel[win] ? MIIM_ARM : CFG;
        last_d     = win;
        cur_d      = win;
        cnt_d      = 12'd0;
        op_d       = win ? req_opcode[3:2] : req_opcode[1:0];
        addr_d     = win ? req_addr[19:10] : req_addr[9:0];
        wr_d       = win ? req_wr_data[63:32] : req_wr_data[31:0];
        sel_d      = req_miim_sel[win];
        ack_d[win] = 1'b1;
      end
      CFG: begin
        cnt_d    = cnt_inc;
        fin      = cnt_q == 12'(CFG_RD_LAT);
        fin_data = host_rd_data;
      end
      MIIM_ARM: begin
        cnt_d   = cnt_inc;
        fin     = cnt_inc == 12'(TIMEOUT);
        fin_err = fin;
        state_d = (!fin && hreq_q) ? MIIM_GAP : state_q;
        hreq_d  = !fin && !hreq_q && host_miim_rdy;
      end
      MIIM_GAP: state_d = MIIM_WAIT;
      MIIM_WAIT: begin
        cnt_d    = cnt_inc;
        fin_err  = cnt_inc == 12'(TIMEOUT);
        fin      = fin_err || host_miim_rdy;
        fin_data = fin_err ? 32'd0 : {16'd0, host_rd_data[15:0]};
      end
      default: state_d = IDLE;
    endcase
    // Completion: report to the owning requester and park the bus at idle values
    if (fin) begin
      state_d       = IDLE;
      done_d[cur_q] = 1'b1;
      err_d[cur_q]  = fin_err;
      rd_d          = cur_q ? {fin_data, rd_q[31:0]} : {rd_q[63:32], fin_data};
      op_d          = 2'b11;
      addr_d        = 10'd0;
      wr_d          = 32'd0;
      sel_d         = 1'b0;
    end
  end
  always_ff @(posedge host_clk) begin
    if (host_reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cur_q   <= 1'b0;
      cnt_q   <= 12'd0;
      op_q    <= 2'b11;
      addr_q  <= 10'd0;
      wr_q    <= 32'd0;
      sel_q   <= 1'b0;
      hreq_q  <= 1'b0;
      ack_q   <= 2'b00;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
      rd_q    <= 64'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      sel_q   <= sel_d;
      hreq_q  <= hreq_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end
  assign req_ack       = ack_q;
  assign req_done      = done_q;
  assign req_err       = err_q;
  assign req_rd_data   = rd_q;
  assign host_opcode   = op_q;
  assign host_addr     = addr_q;
  assign host_wr_data  = wr_q;
  assign host_miim_sel = sel_q;
  assign host_req      = hreq_q;
endmodule

// File: tb/tb_mdioconf_hst_arb.sv
// tb_mdioconf_hst_arb: scoreboard bench; a second instance with TIMEOUT=16 and rdy stuck low covers the MIIM abort
module tb_mdioconf_hst_arb;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst, rdy, rdy_to;
  logic [1:0]  valid, msel;
  logic [3:0]  opcode;
  logic [19:0] addr;
  logic [63:0] wdata;
  logic [31:0] hrd;
  logic [1:0]  ack, done, err, hop, to_ack, to_done, to_err, to_hop;
  logic [63:0] rdata, to_rdata;
  logic [9:0]  haddr, to_haddr;
  logic [31:0] hwd, to_hwd;
  logic        hsel, hreq, to_hsel, to_hreq;
  mdioconf_hst_arb dut (
    .host_clk(clk), .host_reset(rst), .req_valid(valid), .req_opcode(opcode), .req_addr(addr),
    .req_wr_data(wdata), .req_miim_sel(msel), .req_ack(ack), .req_done(done), .req_rd_data(rdata),
    .req_err(err), .host_opcode(hop), .host_addr(haddr), .host_wr_data(hwd), .host_miim_sel(hsel),
    .host_req(hreq), .host_rd_data(hrd), .host_miim_rdy(rdy)
  );
  mdioconf_hst_arb #(.TIMEOUT(16)) u_to (
    .host_clk(clk), .host_reset(rst), .req_valid(valid), .req_opcode(opcode), .req_addr(addr),
    .req_wr_data(wdata), .req_miim_sel(msel), .req_ack(to_ack), .req_done(to_done), .req_rd_data(to_rdata),
    .req_err(to_err), .host_opcode(to_hop), .host_addr(to_haddr), .host_wr_data(to_hwd), .host_miim_sel(to_hsel),
    .host_req(to_hreq), .host_rd_data(hrd), .host_miim_rdy(rdy_to)
  );
  int vectors = 0, miscompares = 0, hreq_cnt = 0, to_hreq_cnt = 0;
  typedef struct {int r; logic [31:0] d; logic e;} exp_t;
  exp_t sb[$];
  exp_t e_m;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    if (hreq) hreq_cnt++;
    if (to_hreq) to_hreq_cnt++;
    for (int i = 0; i < 2; i++) if (done[i]) begin
      chk("ack_done_excl", 64'(ack[i]), 64'd0);
      if (sb.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
      else begin
        e_m = sb.pop_front();
        chk("done_req", 64'(i), 64'(e_m.r));
        chk("rd_data", 64'(rdata[i*32 +: 32]), 64'(e_m.d));
        chk("err", 64'(err[i]), 64'(e_m.e));
      end
    end
  end
  task automatic drive(input int r, input logic [1:0] op, input logic [9:0] a, input logic [31:0] d, input logic s);
    opcode[r*2 +: 2]  = op;
    addr[r*10 +: 10]  = a;
    wdata[r*32 +: 32] = d;
    msel[r]           = s;
    valid[r]          = 1'b1;
  endtask
  task automatic wait_ack(output int w, output int lat);
    lat = 0;
    w = -1;
    while (w < 0 && lat < 50) begin
      @(negedge clk);
      lat++;
      if (ack[0]) w = 0;
      else if (ack[1]) w = 1;
    end
    valid = 2'b00;
    chk("ack_seen", 64'(w >= 0), 64'd1);
  endtask
  task automatic wait_done(input int r);
    int n = 0;
    while (!done[r] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'(done[r]), 64'd1);
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_op"}, 64'(hop), 64'd3);
    chk({tag, "_addr"}, 64'(haddr), 64'd0);
    chk({tag, "_wd"}, 64'(hwd), 64'd0);
    chk({tag, "_sel"}, 64'(hsel), 64'd0);
    chk({tag, "_req"}, 64'(hreq), 64'd0);
    chk({tag, "_ack"}, 64'(ack), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_rd"}, rdata, 64'd0);
  endtask
  initial begin
    int w, lat, n;
    int exp_g[3] = '{0, 1, 0};
    rst = 1'b1; valid = 0; opcode = 0; addr = 0; wdata = 0; msel = 0; hrd = 0; rdy = 0; rdy_to = 0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    // config read, requester 0
    hrd = 32'h1C000000;
    drive(0, 2'b10, 10'h240, 32'd0, 1'b0);
    sb.push_back('{0, 32'h1C000000, 1'b0});
    wait_ack(w, lat);
    chk("cfg_who", 64'(w), 64'd0);
    chk("cfg_lat", 64'(lat), 64'd1);
    for (int k = 0; k < 3; k++) begin
      chk("cfg_addr", 64'(haddr), 64'h240);
      chk("cfg_op", 64'(hop), 64'd2);
      @(negedge clk);
    end
    chk("cfg_done_t4", 64'(done[0]), 64'd1);
    chk("cfg_idle_op", 64'(hop), 64'd3);
    chk("cfg_idle_addr", 64'(haddr), 64'd0);
    // config write, requester 1
    @(negedge clk);
    hrd = 32'h0BADF00D;
    drive(1, 2'b01, 10'h3FF, 32'hCAFE1234, 1'b0);
    sb.push_back('{1, 32'h0BADF00D, 1'b0});
    wait_ack(w, lat);
    chk("wr_who", 64'(w), 64'd1);
    chk("wr_data", 64'(hwd), 64'hCAFE1234);
    chk("wr_op", 64'(hop), 64'd1);
    chk("wr_sel", 64'(hsel), 64'd0);
    wait_done(1);
    chk("rd0_held", 64'(rdata[31:0]), 64'h1C000000);
    // MIIM read, requester 1, rdy drops for 20 cycles
    @(negedge clk);
    rdy = 1'b1;
    hrd = 32'd0;
    hreq_cnt = 0;
    drive(1, 2'b11, 10'h0A1, 32'd0, 1'b1);
    wait_ack(w, lat);
    chk("miim_who", 64'(w), 64'd1);
    chk("miim_sel", 64'(hsel), 64'd1);
    chk("miim_addr", 64'(haddr), 64'h0A1);
    @(negedge clk);
    chk("miim_req_t2", 64'(hreq), 64'd1);
    rdy = 1'b0;
    repeat (20) @(negedge clk);
    hrd = 32'hABCDBEEF;
    rdy = 1'b1;
    sb.push_back('{1, 32'h0000BEEF, 1'b0});
    wait_done(1);
    chk("miim_req_count", 64'(hreq_cnt), 64'd1);
    chk("miim_idle_sel", 64'(hsel), 64'd0);
    // simultaneous requests, three rounds
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      hrd = 32'h1000 + k;
      drive(0, 2'b10, 10'h100 + 10'(k), 32'd0, 1'b0);
      drive(1, 2'b10, 10'h200 + 10'(k), 32'd0, 1'b0);
      sb.push_back('{exp_g[k], 32'h1000 + k, 1'b0});
      wait_ack(w, lat);
      chk("tie_grant", 64'(w), 64'(exp_g[k]));
      wait_done(exp_g[k]);
    end
    // MIIM timeout on the TIMEOUT=16 instance; main instance completes normally
    @(negedge clk);
    rdy = 1'b1;
    hrd = 32'h12345678;
    to_hreq_cnt = 0;
    drive(0, 2'b11, 10'h011, 32'd0, 1'b1);
    sb.push_back('{0, 32'h00005678, 1'b0});
    wait_ack(w, lat);
    chk("to_ack", 64'(to_ack[0]), 64'd1);
    n = 0;
    while (!to_done[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("to_latency", 64'(n), 64'd16);
    chk("to_err", 64'(to_err[0]), 64'd1);
    chk("to_rd", 64'(to_rdata[31:0]), 64'd0);
    chk("to_idle_op", 64'(to_hop), 64'd3);
    chk("to_idle_sel", 64'(to_hsel), 64'd0);
    chk("to_no_req", 64'(to_hreq_cnt), 64'd0);
    chk("to_sb_empty", 64'(sb.size()), 64'd0);
    // reset during MIIM_WAIT
    @(negedge clk);
    drive(0, 2'b11, 10'h055, 32'd0, 1'b1);
    wait_ack(w, lat);
    @(negedge clk);
    rdy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("abort");
    rst = 1'b0;
    rdy = 1'b1;
    hrd = 32'h55AA55AA;
    drive(0, 2'b10, 10'h001, 32'd0, 1'b0);
    drive(1, 2'b10, 10'h002, 32'd0, 1'b0);
    sb.push_back('{0, 32'h55AA55AA, 1'b0});
    wait_ack(w, lat);
    chk("post_reset_grant", 64'(w), 64'd0);
    wait_done(0);
    @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
